// File: rtl/sym_eval_ctrl.sv
// ---------------------------------------------------------------------------
// sym_eval_ctrl
//
// Sequencer for one symmetry-aware function evaluation. Each accepted operand
// is folded to |x|, issued to a shared positive-domain approximation core, and
// the core's answer is restored using the selected symmetry (odd,
// point-symmetric about 0.5, even, or bypass). One operand is in flight at a
// time.
//
// Parameters
//   M        integer bits including sign
//   N        fraction bits (fixed-point 1.0 = 1 << N)
//   TIMEOUT  maximum cycles spent waiting for the core before aborting (>= 2)
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready        operand handshake; in_x signed operand, in_mode symmetry
//                            (00 odd, 01 f(-x)=1-f(x), 10 even, 11 bypass)
//   core_start               one-cycle issue pulse to the core
//   core_x                   |x| presented to the core, held until next operand
//   core_done/core_y         single-cycle core result pulse and signed result
//   out_valid/out_ready      result handshake; out_y signed restored result
//   busy                     controller is not idle
//   err_timeout              one-cycle pulse when the core fails to answer
// ---------------------------------------------------------------------------
module sym_eval_ctrl #(
    parameter int M       = 4,
    parameter int N       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M+N-1:0]   in_x,
    input  logic [1:0]       in_mode,
    output logic             core_start,
    output logic [M+N-1:0]   core_x,
    input  logic             core_done,
    input  logic [M+N-1:0]   core_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M+N-1:0]   out_y,
    output logic             busy,
    output logic             err_timeout
);

    localparam int W  = M + N;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

    // Two guard bits are enough for every intermediate result (negation of
    // the most-negative value, and 1.0 minus the most-negative value).
    localparam logic signed [W+1:0] MAX_EXT = $signed({3'b000, {(W-1){1'b1}}});
    localparam logic signed [W+1:0] MIN_EXT = $signed({3'b111, {(W-1){1'b0}}});
    localparam logic signed [W+1:0] ONE_EXT = $signed({{(W+1-N){1'b0}}, 1'b1, {N{1'b0}}});

    localparam logic [1:0] MODE_ODD    = 2'b00;
    localparam logic [1:0] MODE_HALF   = 2'b01;
    localparam logic [1:0] MODE_EVEN   = 2'b10;
    localparam logic [1:0] MODE_BYPASS = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ISSUE,
        S_WAIT,
        S_POST,
        S_OUT
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    x_q, x_d;
    logic [1:0]      mode_q, mode_d;
    logic            sign_q, sign_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    y_q, y_d;
    logic [W-1:0]    core_x_q, core_x_d;
    logic [W-1:0]    out_y_q, out_y_d;
    logic            core_start_q, core_start_d;
    logic            out_valid_q, out_valid_d;
    logic            err_timeout_q, err_timeout_d;

    logic signed [W+1:0] x_ext;
    logic signed [W+1:0] y_ext;

    // Clamp a widened signed value into the W-bit signed range.
    function automatic logic [W-1:0] sat_w(input logic signed [W+1:0] v);
        logic [W-1:0] r;
        if (v > MAX_EXT) begin
            r = MAX_EXT[W-1:0];
        end else if (v < MIN_EXT) begin
            r = MIN_EXT[W-1:0];
        end else begin
            r = v[W-1:0];
        end
        return r;
    endfunction

    assign x_ext = $signed({{2{x_q[W-1]}}, x_q});
    assign y_ext = $signed({{2{y_q[W-1]}}, y_q});

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        mode_d        = mode_q;
        sign_d        = sign_q;
        cnt_d         = cnt_q;
        y_d           = y_q;
        core_x_d      = core_x_q;
        out_y_d       = out_y_q;
        core_start_d  = 1'b0;
        out_valid_d   = out_valid_q;
        err_timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = in_x;
                    mode_d  = in_mode;
                    sign_d  = in_x[W-1];
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                core_x_d = sign_q ? sat_w(-x_ext) : x_q;
                if (mode_q == MODE_BYPASS) begin
                    state_d = S_POST;
                end else begin
                    core_start_d = 1'b1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A done pulse here cannot belong to this issue; ignore it.
                cnt_d   = CW'(1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    y_d     = core_y;
                    state_d = S_POST;
                end else if (cnt_q == TO_CNT) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_POST: begin
                case (mode_q)
                    MODE_ODD:  out_y_d = sign_q ? sat_w(-y_ext) : y_q;
                    MODE_HALF: out_y_d = sign_q ? sat_w(ONE_EXT - y_ext) : y_q;
                    MODE_EVEN: out_y_d = y_q;
                    default:   out_y_d = x_q;
                endcase
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            x_q           <= '0;
            mode_q        <= '0;
            sign_q        <= 1'b0;
            cnt_q         <= '0;
            y_q           <= '0;
            core_x_q      <= '0;
            out_y_q       <= '0;
            core_start_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            mode_q        <= mode_d;
            sign_q        <= sign_d;
            cnt_q         <= cnt_d;
            y_q           <= y_d;
            core_x_q      <= core_x_d;
            out_y_q       <= out_y_d;
            core_start_q  <= core_start_d;
            out_valid_q   <= out_valid_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // in_ready is gated by rst so nothing is accepted while reset is held.
    assign in_ready    = (state_q == S_IDLE) && !rst;
    assign busy        = (state_q != S_IDLE);
    assign core_start  = core_start_q;
    assign core_x      = core_x_q;
    assign out_valid   = out_valid_q;
    assign out_y       = out_y_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_sym_eval_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sym_eval_ctrl
//
// Self-checking bench for sym_eval_ctrl. Directed cases cover the documented
// examples and saturation corners; a randomized loop follows. Expected values
// come from plain integer arithmetic on the symmetry rules.
// ---------------------------------------------------------------------------
module tb_sym_eval_ctrl;

    localparam int M  = 4;
    localparam int N  = 8;
    localparam int W  = M + N;
    localparam int TO = 16;
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam int MINV = -(1 << (W - 1));

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_x;
    logic [1:0]    in_mode;
    logic          core_start;
    logic [W-1:0]  core_x;
    logic          core_done;
    logic [W-1:0]  core_y;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_y;
    logic          busy;
    logic          err_timeout;

    int checks = 0;
    int errors = 0;

    sym_eval_ctrl #(.M(M), .N(N), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_mode     (in_mode),
        .core_start  (core_start),
        .core_x      (core_x),
        .core_done   (core_done),
        .core_y      (core_y),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_y       (out_y),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int clamp(input int v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    function automatic int model_out(input int x, input int mode, input int y);
        int r;
        case (mode)
            0:       r = (x < 0) ? -y : y;
            1:       r = (x < 0) ? (1 << N) - y : y;
            2:       r = y;
            default: r = x;
        endcase
        return clamp(r);
    endfunction

    // Wait for IDLE, present the operand, and step past the accept edge.
    task automatic do_accept(input int x, input int mode);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_x     = x[W-1:0];
        in_mode  = mode[1:0];
        step();
        // Noise on the input while busy must not be latched.
        in_valid = 1'($urandom_range(0, 1));
        in_x     = W'($urandom);
        in_mode  = 2'($urandom);
        check("busy_pre", busy, 1);
        check("in_ready_busy", in_ready, 0);
    endtask

    task automatic run_op(input int x, input int mode, input int y,
                          input int lat, input int hold);
        int ex_abs;
        int ex_out;
        ex_abs = clamp((x < 0) ? -x : x);
        ex_out = model_out(x, mode, y);
        out_ready = 1'b0;
        do_accept(x, mode);
        step();                                   // accept + 2
        check("core_x", $signed({1'b0, core_x}), ex_abs);
        if (mode == 3) begin
            check("core_start_bypass", core_start, 0);
        end else begin
            check("core_start", core_start, 1);
            // Spurious done while issuing is ignored.
            core_done = 1'($urandom_range(0, 1));
            core_y    = W'($urandom);
            for (int k = 1; k <= lat; k++) begin
                step();                           // accept + 2 + k
                check("core_start_off", core_start, 0);
                core_done = (k == lat);
                core_y    = (k == lat) ? y[W-1:0] : W'($urandom);
            end
            step();                               // POST
            core_done = 1'b0;
            check("out_valid_post", out_valid, 0);
        end
        step();                                   // OUT
        in_valid = 1'b0;
        check("out_valid", out_valid, 1);
        check("out_y", $signed(out_y), ex_out);
        for (int h = 0; h < hold; h++) begin
            step();
            check("out_valid_hold", out_valid, 1);
            check("out_y_hold", $signed(out_y), ex_out);
            check("in_ready_hold", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("out_valid_done", out_valid, 0);
        check("in_ready_done", in_ready, 1);
        $display("op x=%0d mode=%0d y=%0d lat=%0d hold=%0d -> out_y=%0d exp=%0d",
                 x, mode, y, lat, hold, $signed(out_y), ex_out);
    endtask

    task automatic run_timeout(input int x);
        do_accept(x, 0);
        step();
        check("core_start_to", core_start, 1);
        for (int k = 1; k <= TO; k++) begin
            step();
            check("err_early", err_timeout, 0);
            check("busy_wait", busy, 1);
        end
        step();
        in_valid = 1'b0;
        check("err_pulse", err_timeout, 1);
        check("busy_after_to", busy, 0);
        check("out_valid_to", out_valid, 0);
        core_done = 1'b1;
        core_y    = W'($urandom);
        step();
        core_done = 1'b0;
        check("err_cleared", err_timeout, 0);
        check("late_done_busy", busy, 0);
        check("late_done_valid", out_valid, 0);
        step();
        check("late_done_idle", in_ready, 1);
        $display("timeout x=%0d err_timeout seen after %0d wait cycles", x, TO);
    endtask

    task automatic rst_in_wait();
        do_accept(500, 0);
        step();                                   // ISSUE
        step();                                   // WAIT
        step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_core_x", core_x, 0);
        check("rst_core_start", core_start, 0);
        step();
        step();
        rst = 1'b0;
        step();
        check("rst_release_ready", in_ready, 1);
        $display("reset in WAIT cleared state");
    endtask

    initial begin
        int x, mode, y, lat, hold;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_mode   = '0;
        core_done = 1'b0;
        core_y    = '0;
        out_ready = 1'b0;
        step();
        step();
        check("reset_in_ready", in_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_core_start", core_start, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_err", err_timeout, 0);
        check("reset_core_x", core_x, 0);
        check("reset_out_y", out_y, 0);
        rst = 1'b0;
        step();
        check("post_reset_ready", in_ready, 1);

        run_op(-384, 0, 232, 3, 0);
        run_op(-256, 1, 187, 2, 0);
        run_op(256, 1, 187, 1, 0);
        run_op(-512, 2, 50, 4, 0);
        run_op(-7, 3, 0, 0, 0);
        run_op(-2048, 0, -2048, 2, 0);
        run_op(-100, 1, -2048, 1, 0);
        run_op(-2048, 3, 0, 0, 2);
        run_timeout(-300);
        run_op(1000, 0, 77, 2, 5);
        rst_in_wait();
        run_op(300, 0, -5, 1, 0);

        for (int i = 0; i < 40; i++) begin
            x    = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
            mode = int'($urandom_range(0, 3));
            y    = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
            lat  = int'($urandom_range(1, 6));
            hold = int'($urandom_range(0, 3));
            run_op(x, mode, y, lat, hold);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
